// File: rtl/color_analysis_hls_deadlock_report_pkg.sv
// Shared definitions for the HLS deadlock report block.
//   state_e   : report FSM states
//   *_W       : widths of the captured vectors, the timestamp and the run counter
package color_analysis_deadlock_pkg;

  localparam int unsigned IDLE_W  = 21;
  localparam int unsigned CHAN_W  = 12;
  localparam int unsigned AXIS_W  = 5;
  localparam int unsigned STAMP_W = 32;
  // Run counter must hold CONFIRM_CYCLES up to 65535.
  localparam int unsigned RUN_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    CONFIRM,
    REPORT,
    HOLD
  } state_e;

endpackage

// File: rtl/color_analysis_hls_deadlock_report_if.sv
// Report bus bundle: valid/ready handshake plus the captured snapshot.
//   master : producer (drives valid and snapshot, receives ready)
//   slave  : consumer (receives valid and snapshot, drives ready)
interface color_analysis_hls_deadlock_report_if;
  import color_analysis_deadlock_pkg::*;

  logic               valid;
  logic               ready;
  logic [IDLE_W-1:0]  idle;
  logic [CHAN_W-1:0]  chan_block;
  logic [AXIS_W-1:0]  axis_block;
  logic [STAMP_W-1:0] stamp;

  modport master (output valid, idle, chan_block, axis_block, stamp, input ready);
  modport slave  (input valid, idle, chan_block, axis_block, stamp, output ready);
endinterface

// File: rtl/color_analysis_hls_deadlock_confirm_cnt.sv
// Run-length counter for the block indication.
//   clock, reset : rising-edge clock, async active-low reset
//   inc          : count one more qualifying cycle
//   clr          : zero the count (wins over inc)
//   done         : combinational look-ahead, high when this inc reaches CONFIRM_CYCLES
module color_analysis_hls_deadlock_confirm_cnt
  import color_analysis_deadlock_pkg::*;
#(
  parameter int unsigned CONFIRM_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic done
);

  logic [RUN_W-1:0] run_q;
  logic [RUN_W:0]   run_nxt;

  assign run_nxt = {1'b0, run_q} + {{RUN_W{1'b0}}, 1'b1};
  // Compare the incremented value so the terminal sample itself triggers done.
  assign done    = inc && (run_nxt == (RUN_W+1)'(CONFIRM_CYCLES));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_q <= '0;
    end else if (clr) begin
      run_q <= '0;
    end else if (inc) begin
      run_q <= run_nxt[RUN_W-1:0];
    end
  end

endmodule

// File: rtl/color_analysis_hls_deadlock_report.sv
// Confirms a persistent HLS dataflow deadlock indication, captures one
// snapshot report per block episode and keeps a sticky flag plus a
// saturating event counter.
//   clock, reset        : rising-edge clock, async active-low reset
//   block               : raw deadlock indication
//   inst_*/axis_*_sigs  : vectors captured into the report
//   clear               : sync clear of deadlock and event_count
//   report_valid/ready  : report handshake
//   report_*            : captured snapshot and timestamp
//   deadlock            : sticky flag
//   event_count         : saturating count of confirmed deadlocks
// Build option: DEADLOCK_SNAPSHOT_EN enables snapshot registers and timer;
// without it report_idle/chan_block/axis_block/stamp are tied to zero.
module color_analysis_hls_deadlock_report
  import color_analysis_deadlock_pkg::*;
#(
  parameter int unsigned CONFIRM_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               block,
  input  logic [IDLE_W-1:0]  inst_idle_sigs,
  input  logic [CHAN_W-1:0]  inst_block_sigs,
  input  logic [AXIS_W-1:0]  axis_block_sigs,
  input  logic               clear,
  input  logic               report_ready,
  output logic               report_valid,
  output logic [IDLE_W-1:0]  report_idle,
  output logic [CHAN_W-1:0]  report_chan_block,
  output logic [AXIS_W-1:0]  report_axis_block,
  output logic [STAMP_W-1:0] report_stamp,
  output logic               deadlock,
  output logic [CNT_W-1:0]   event_count
);

  state_e           state_q;
  logic             valid_q;
  logic             deadlock_q, deadlock_d;
  logic [CNT_W-1:0] evt_q, evt_d;
  logic             run_inc, run_clr, run_done;
  logic             capture, accept;

  assign run_inc = block && ((state_q == IDLE) || (state_q == CONFIRM));
  assign run_clr = run_done || ((state_q == CONFIRM) && !block);
  assign capture = run_done;
  assign accept  = valid_q && report_ready;

  color_analysis_hls_deadlock_confirm_cnt #(
    .CONFIRM_CYCLES(CONFIRM_CYCLES)
  ) u_confirm_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (run_inc),
    .clr   (run_clr),
    .done  (run_done)
  );

  // Clear first, then capture on top of it: a coinciding capture leaves count=1.
  always_comb begin
    evt_d      = evt_q;
    deadlock_d = deadlock_q;
    if (clear) begin
      evt_d      = '0;
      deadlock_d = 1'b0;
    end
    if (capture) begin
      deadlock_d = 1'b1;
      if (clear)       evt_d = CNT_W'(1);
      else if (&evt_q) evt_d = evt_q;
      else             evt_d = evt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      deadlock_q <= 1'b0;
      evt_q      <= '0;
    end else begin
      deadlock_q <= deadlock_d;
      evt_q      <= evt_d;
      unique case (state_q)
        IDLE:    if (block) state_q <= run_done ? REPORT : CONFIRM;
        CONFIRM: begin
          if (!block)        state_q <= IDLE;
          else if (run_done) state_q <= REPORT;
        end
        REPORT:  if (accept) state_q <= block ? HOLD : IDLE;
        HOLD:    if (!block) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (capture)     valid_q <= 1'b1;
      else if (accept) valid_q <= 1'b0;
    end
  end

  assign report_valid = valid_q;
  assign deadlock     = deadlock_q;
  assign event_count  = evt_q;

`ifdef DEADLOCK_SNAPSHOT_EN
  logic [STAMP_W-1:0] timer_q, stamp_q;
  logic [IDLE_W-1:0]  idle_q;
  logic [CHAN_W-1:0]  chan_q;
  logic [AXIS_W-1:0]  axis_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
      stamp_q <= '0;
      idle_q  <= '0;
      chan_q  <= '0;
      axis_q  <= '0;
    end else begin
      timer_q <= timer_q + STAMP_W'(1);
      if (capture) begin
        stamp_q <= timer_q;
        idle_q  <= inst_idle_sigs;
        chan_q  <= inst_block_sigs;
        axis_q  <= axis_block_sigs;
      end
    end
  end

  assign report_idle       = idle_q;
  assign report_chan_block = chan_q;
  assign report_axis_block = axis_q;
  assign report_stamp      = stamp_q;
`else
  logic unused_snapshot_inputs;
  assign unused_snapshot_inputs = ^{inst_idle_sigs, inst_block_sigs, axis_block_sigs};

  assign report_idle       = '0;
  assign report_chan_block = '0;
  assign report_axis_block = '0;
  assign report_stamp      = '0;
`endif

endmodule

// File: tb/tb_color_analysis_hls_deadlock_report.sv
module tb_color_analysis_hls_deadlock_report;
  import color_analysis_deadlock_pkg::*;

`ifdef DEADLOCK_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic clock;
  logic reset;

  // DUT A: CONFIRM_CYCLES=16, CNT_W=8
  logic        blk_a, clr_a, dl_a;
  logic [20:0] idle_a;
  logic [11:0] chan_a;
  logic [4:0]  axis_a;
  logic [7:0]  ec_a;
  color_analysis_hls_deadlock_report_if rif_a ();

  // DUT B: CONFIRM_CYCLES=1, CNT_W=2
  logic        blk_b, clr_b, dl_b;
  logic [20:0] idle_b;
  logic [11:0] chan_b;
  logic [4:0]  axis_b;
  logic [1:0]  ec_b;
  color_analysis_hls_deadlock_report_if rif_b ();

  color_analysis_hls_deadlock_report #(.CONFIRM_CYCLES(16), .CNT_W(8)) dut_a (
    .clock(clock), .reset(reset), .block(blk_a),
    .inst_idle_sigs(idle_a), .inst_block_sigs(chan_a), .axis_block_sigs(axis_a),
    .clear(clr_a), .report_ready(rif_a.ready), .report_valid(rif_a.valid),
    .report_idle(rif_a.idle), .report_chan_block(rif_a.chan_block),
    .report_axis_block(rif_a.axis_block), .report_stamp(rif_a.stamp),
    .deadlock(dl_a), .event_count(ec_a)
  );

  color_analysis_hls_deadlock_report #(.CONFIRM_CYCLES(1), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .block(blk_b),
    .inst_idle_sigs(idle_b), .inst_block_sigs(chan_b), .axis_block_sigs(axis_b),
    .clear(clr_b), .report_ready(rif_b.ready), .report_valid(rif_b.valid),
    .report_idle(rif_b.idle), .report_chan_block(rif_b.chan_block),
    .report_axis_block(rif_b.axis_block), .report_stamp(rif_b.stamp),
    .deadlock(dl_b), .event_count(ec_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        b;
    logic [20:0] idle;
    logic        rdy;
    logic        clr;
    logic        ev;
    logic        ed;
    logic [7:0]  ec;
    logic        snap;
    logic [20:0] xidle;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic add(input logic b, input logic [20:0] idle, input logic rdy, input logic clr,
                     input logic ev, input logic ed, input logic [7:0] ec,
                     input logic snap, input logic [20:0] xidle);
    vec_t v;
    v.b = b; v.idle = idle; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.ed = ed; v.ec = ec; v.snap = snap; v.xidle = xidle;
    tbl.push_back(v);
  endtask

  task automatic drive_a(input logic b, input logic [20:0] idle, input logic rdy, input logic clr);
    blk_a = b; idle_a = idle; chan_a = idle[20:9]; axis_a = idle[4:0];
    rif_a.ready = rdy; clr_a = clr;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, " valid"}, 32'(rif_a.valid), 32'd0);
    chk({tag, " deadlock"}, 32'(dl_a), 32'd0);
    chk({tag, " count"}, 32'(ec_a), 32'd0);
    chk({tag, " idle"}, 32'(rif_a.idle), 32'd0);
    chk({tag, " chan"}, 32'(rif_a.chan_block), 32'd0);
    chk({tag, " axis"}, 32'(rif_a.axis_block), 32'd0);
    chk({tag, " stamp"}, rif_a.stamp, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    drive_a(1'b0, '0, 1'b0, 1'b0);
    blk_b = 1'b0; idle_b = '0; chan_b = '0; axis_b = '0; rif_b.ready = 1'b0; clr_b = 1'b0;

    // ---- vector table for DUT A ----
    for (int i = 0; i < 15; i++) add(1, 21'h0, 0, 0, 0, 0, 0, 0, 0);         // short pulse
    add(0, 21'h0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) add(1, 21'h12345, 0, 0, 0, 0, 0, 0, 0);     // detection
    add(1, 21'h0F0F0, 0, 0, 1, 1, 1, 1, 21'h0F0F0);
    for (int i = 0; i < 5; i++) add(1, 21'h1FFFF, 0, 0, 1, 1, 1, 1, 21'h0F0F0);
    for (int i = 0; i < 2; i++) add(0, 21'h1FFFF, 0, 0, 1, 1, 1, 1, 21'h0F0F0);
    add(1, 21'h1FFFF, 1, 0, 0, 1, 1, 1, 21'h0F0F0);                         // accept, block high
    for (int i = 0; i < 100; i++) add(1, 21'h0AAAA, 1'(i), 0, 0, 1, 1, 0, 0); // HOLD
    add(0, 21'h0, 0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 15; i++) add(1, 21'h00001, 0, 0, 0, 1, 1, 0, 0);
    add(1, 21'h00ABC, 0, 0, 1, 1, 2, 1, 21'h00ABC);
    add(0, 21'h0, 1, 0, 0, 1, 2, 1, 21'h00ABC);                             // accept, block low
    for (int i = 0; i < 15; i++) add(1, 21'h1F000, 0, 0, 0, 1, 2, 0, 0);
    add(1, 21'h15555, 0, 1, 1, 1, 1, 1, 21'h15555);                         // clear on capture
    add(0, 21'h0, 0, 1, 1, 0, 0, 1, 21'h15555);                             // clear alone
    add(0, 21'h0, 1, 0, 0, 0, 0, 1, 21'h15555);
    add(1, 21'h0, 0, 0, 0, 0, 0, 0, 0);

    // ---- reset state ----
    #12;
    chk_a_zero("reset_state");
    chk("reset_state B valid", 32'(rif_b.valid), 32'd0);
    chk("reset_state B count", 32'(ec_b), 32'd0);
    @(posedge clock);
    #3 reset = 1'b1;

    // ---- saturation on DUT B (CONFIRM_CYCLES=1, CNT_W=2) ----
    for (int k = 1; k <= 5; k++) begin
      blk_b = 1'b1; rif_b.ready = 1'b0;
      step();
      chk("sat capture valid", 32'(rif_b.valid), 32'd1);
      chk("sat count", 32'(ec_b), (k < 3) ? 32'(k) : 32'd3);
      chk("sat deadlock", 32'(dl_b), 32'd1);
      blk_b = 1'b0; rif_b.ready = 1'b1;
      step();
      chk("sat accept valid", 32'(rif_b.valid), 32'd0);
    end
    rif_b.ready = 1'b0;

    // ---- table-driven run on DUT A ----
    foreach (tbl[i]) begin
      drive_a(tbl[i].b, tbl[i].idle, tbl[i].rdy, tbl[i].clr);
      step();
      chk("tbl valid", 32'(rif_a.valid), 32'(tbl[i].ev));
      chk("tbl deadlock", 32'(dl_a), 32'(tbl[i].ed));
      chk("tbl count", 32'(ec_a), 32'(tbl[i].ec));
      if (tbl[i].snap) begin
        chk("tbl idle", 32'(rif_a.idle), SNAP ? 32'(tbl[i].xidle) : 32'd0);
        chk("tbl chan", 32'(rif_a.chan_block), SNAP ? 32'(tbl[i].xidle[20:9]) : 32'd0);
        chk("tbl axis", 32'(rif_a.axis_block), SNAP ? 32'(tbl[i].xidle[4:0]) : 32'd0);
      end
    end

    // ---- reset during REPORT ----
    drive_a(1'b0, '0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 16; i++) begin
      drive_a(1'b1, 21'h0F0F0, 1'b0, 1'b0);
      step();
    end
    chk("pre-reset valid", 32'(rif_a.valid), 32'd1);
    chk("pre-reset count", 32'(ec_a), 32'd1);
    #2 reset = 1'b0;
    #1 chk_a_zero("reset_in_report");
    step(); step();
    #2 reset = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("post-reset valid", 32'(rif_a.valid), (i == 16) ? 32'd1 : 32'd0);
    end
    chk("post-reset count", 32'(ec_a), 32'd1);
    chk("post-reset stamp", rif_a.stamp, SNAP ? 32'd15 : 32'd0);
    chk("post-reset idle", 32'(rif_a.idle), SNAP ? 32'h0F0F0 : 32'd0);

    // ---- reset during CONFIRM ----
    drive_a(1'b0, 21'h0F0F0, 1'b1, 1'b0);
    step();
    chk("accept before confirm", 32'(rif_a.valid), 32'd0);
    drive_a(1'b1, 21'h0F0F0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step();
    chk("mid-confirm valid", 32'(rif_a.valid), 32'd0);
    chk("mid-confirm count", 32'(ec_a), 32'd1);
    #2 reset = 1'b0;
    #1 chk_a_zero("reset_in_confirm");
    step();
    #2 reset = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("confirm-reset valid", 32'(rif_a.valid), (i == 16) ? 32'd1 : 32'd0);
    end
    chk("confirm-reset count", 32'(ec_a), 32'd1);
    chk("confirm-reset deadlock", 32'(dl_a), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
